// File: rtl/riscv_multicycle_core_if.sv
// Shared word-wide memory port: valid/ready request channel
// plus an rvalid response channel.
interface riscv_multicycle_core_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I/RV32E core sharing one memory port
// for fetch and load/store; halts on illegal or misaligned ops.
module riscv_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32,
    parameter int          CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    riscv_multicycle_core_if.master mem,
    output logic                    halted,
    output logic                    retire,
    output logic [CNT_W-1:0]        instret_count,
    output logic [31:0]             pc_out,
    output logic [31:0]             instruction_out
);
    localparam int RW = $clog2(NUM_REGS);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH, S_IWAIT, S_DECODE, S_EXEC, S_MEM, S_DWAIT, S_TRAP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rf [NUM_REGS];
    logic        valid_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    assign mem.mem_valid  = valid_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q;
    assign mem.mem_wdata  = wdata_q;
    assign pc_out          = pc;
    assign instruction_out = ir;

    logic [6:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_opimm, is_op;

    assign is_lui    = opc == OPC_LUI;
    assign is_auipc  = opc == OPC_AUIPC;
    assign is_jal    = opc == OPC_JAL;
    assign is_jalr   = opc == OPC_JALR;
    assign is_branch = opc == OPC_BRANCH;
    assign is_load   = opc == OPC_LOAD;
    assign is_store  = opc == OPC_STORE;
    assign is_opimm  = opc == OPC_OPIMM;
    assign is_op     = opc == OPC_OP;

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;

    assign i_imm = {{21{ir[31]}}, ir[30:20]};
    assign s_imm = {{21{ir[31]}}, ir[30:25], ir[11:7]};
    assign b_imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign u_imm = {ir[31:12], 12'b0};
    assign j_imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

    logic alt_f7;
    logic opimm_ok;
    logic op_ok;

    assign alt_f7   = f7 == 7'b0100000;
    assign opimm_ok = (f3 == 3'b001) ? (f7 == 7'b0) :
                      (f3 == 3'b101) ? (f7 == 7'b0 || alt_f7) : 1'b1;
    assign op_ok    = (f7 == 7'b0) ||
                      (alt_f7 && (f3 == 3'b000 || f3 == 3'b101));

    logic [31:0] imm;
    logic        legal;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;

    always_comb begin
        imm     = '0;
        legal   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        unique case (1'b1)
            is_lui, is_auipc: begin
                imm = u_imm; legal = 1'b1; use_rd = 1'b1;
            end
            is_jal: begin
                imm = j_imm; legal = 1'b1; use_rd = 1'b1;
            end
            is_jalr: begin
                imm = i_imm; legal = f3 == 3'b000;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            is_branch: begin
                imm = b_imm; legal = f3[2:1] != 2'b01;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            is_load: begin
                imm = i_imm; legal = f3 == 3'b010;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            is_store: begin
                imm = s_imm; legal = f3 == 3'b010;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            is_opimm: begin
                imm = i_imm; legal = opimm_ok;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            is_op: begin
                legal = op_ok;
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: ;
        endcase
    end

    function automatic logic reg_bad(input logic [4:0] r);
        return int'(r) >= NUM_REGS;
    endfunction

    logic illegal;

    assign illegal = !legal ||
                     (use_rd  && reg_bad(rd))  ||
                     (use_rs1 && reg_bad(rs1)) ||
                     (use_rs2 && reg_bad(rs2));

    logic [31:0] alu_b;
    logic [4:0]  sh;
    logic [31:0] alu;
    logic        take;

    assign alu_b = is_op ? op_b : imm;
    assign sh    = alu_b[4:0];

    always_comb begin
        alu = '0;
        unique case (f3)
            3'b000: alu = (is_op && f7[5]) ? op_a - alu_b : op_a + alu_b;
            3'b001: alu = op_a << sh;
            3'b010: alu = {31'b0, $signed(op_a) < $signed(alu_b)};
            3'b011: alu = {31'b0, op_a < alu_b};
            3'b100: alu = op_a ^ alu_b;
            3'b101: alu = f7[5] ? 32'($signed(op_a) >>> sh) : op_a >> sh;
            3'b110: alu = op_a | alu_b;
            3'b111: alu = op_a & alu_b;
            default: ;
        endcase
    end

    always_comb begin
        take = 1'b0;
        unique case (f3)
            3'b000: take = op_a == op_b;
            3'b001: take = op_a != op_b;
            3'b100: take = $signed(op_a) < $signed(op_b);
            3'b101: take = $signed(op_a) >= $signed(op_b);
            3'b110: take = op_a < op_b;
            3'b111: take = op_a >= op_b;
            default: ;
        endcase
    end

    logic [31:0] pc_plus4;
    logic [31:0] pc_imm;
    logic [31:0] a_imm;
    logic [31:0] tgt;
    logic [31:0] next_pc;
    logic [31:0] rd_val;
    logic        jump;
    logic        bad_tgt;
    logic        is_mem;

    assign pc_plus4 = pc + 32'd4;
    assign pc_imm   = pc + imm;
    assign a_imm    = op_a + imm;
    // JALR drops bit 0 before the alignment check
    assign tgt      = is_jalr ? {a_imm[31:1], 1'b0} : pc_imm;
    assign jump     = is_jal || is_jalr || (is_branch && take);
    assign bad_tgt  = jump && (tgt[1:0] != 2'b00);
    assign next_pc  = jump ? tgt : pc_plus4;
    assign is_mem   = is_load || is_store;
    assign rd_val   = is_lui               ? imm      :
                      is_auipc             ? pc_imm   :
                      (is_jal || is_jalr)  ? pc_plus4 : alu;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_FETCH;
            pc            <= RESET_PC;
            ir            <= '0;
            op_a          <= '0;
            op_b          <= '0;
            valid_q       <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            retire        <= 1'b0;
            halted        <= 1'b0;
            instret_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            retire <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= pc;
                    end else if (mem.mem_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_IWAIT;
                    end
                end
                S_IWAIT: begin
                    if (mem.mem_rvalid) begin
                        ir    <= mem.mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (illegal) begin
                        halted <= 1'b1;
                        state  <= S_TRAP;
                    end else begin
                        op_a  <= (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];
                        op_b  <= (rs2 == 5'd0) ? '0 : rf[rs2[RW-1:0]];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem) begin
                        if (a_imm[1:0] != 2'b00) begin
                            halted <= 1'b1;
                            state  <= S_TRAP;
                        end else begin
                            valid_q <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= a_imm;
                            wdata_q <= op_b;
                            state   <= S_MEM;
                        end
                    end else if (bad_tgt) begin
                        halted <= 1'b1;
                        state  <= S_TRAP;
                    end else begin
                        if (!is_branch && rd != 5'd0)
                            rf[rd[RW-1:0]] <= rd_val;
                        pc            <= next_pc;
                        retire        <= 1'b1;
                        instret_count <= instret_count + CNT_ONE;
                        valid_q       <= 1'b1;
                        we_q          <= 1'b0;
                        addr_q        <= next_pc;
                        state         <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ready) begin
                        valid_q <= 1'b0;
                        we_q    <= 1'b0;
                        state   <= S_DWAIT;
                    end
                end
                S_DWAIT: begin
                    if (mem.mem_rvalid) begin
                        if (is_load && rd != 5'd0)
                            rf[rd[RW-1:0]] <= mem.mem_rdata;
                        pc            <= pc_plus4;
                        retire        <= 1'b1;
                        instret_count <= instret_count + CNT_ONE;
                        valid_q       <= 1'b1;
                        we_q          <= 1'b0;
                        addr_q        <= pc_plus4;
                        state         <= S_FETCH;
                    end
                end
                S_TRAP: halted <= 1'b1;
                default: begin
                    halted <= 1'b1;
                    state  <= S_TRAP;
                end
            endcase
        end
    end
endmodule
